// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Bundles the FIFO read port and the valid/ready output stream of
// fifo_stream_reader.
//   master modport: the reader's side. It drives fifo_rd_en_o and the stream
//                   outputs, and takes fifo_empty_i, fifo_data_i and m_ready_i.
//   slave modport : the environment's side (FIFO plus downstream consumer).
// Signal names carry the reader's port names, so _i/_o is seen from the reader.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty_i;
  logic                  fifo_rd_en_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;
  logic [15:0]           beat_cnt_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, beat_cnt_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, beat_cnt_o
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a fifo_buffer read port (one-cycle read latency) and presents the
// words as a valid/ready stream. A 2-entry buffer hides the read latency, so
// the stream sustains one beat per clock. m_last_o marks every BURST_LEN-th
// beat, and beat_cnt_o counts all transferred beats (16-bit, wraps).
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : fifo_stream_reader_if.master (FIFO read port and output stream)
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fifo_stream_reader_if.master bus
);
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [1:0]            occ_reg, occ_next, occ_after_pop;
  logic                  pend_reg;
  logic [15:0]           burst_idx_reg, burst_idx_next;
  logic [15:0]           beat_cnt_reg, beat_cnt_next;
  logic [DATA_WIDTH-1:0] entry0_reg, entry0_next;
  logic [DATA_WIDTH-1:0] entry1_reg, entry1_next;
  logic [2:0]            committed;
  logic                  valid;
  logic                  pop;
  logic                  rd_en;

  assign valid         = (occ_reg != 2'd0);
  assign pop           = valid & bus.m_ready_i;
  assign occ_after_pop = occ_reg - {1'b0, pop};
  // Words held after this edge, counting the one arriving from the FIFO.
  // A new read is only issued if its word is guaranteed a free entry.
  assign committed     = {1'b0, occ_after_pop} + {2'b00, pend_reg};
  assign rd_en         = !rst_i & !bus.fifo_empty_i & (committed < 3'd2);

  always_comb begin
    entry0_next    = entry0_reg;
    entry1_next    = entry1_reg;
    occ_next       = committed[1:0];
    burst_idx_next = burst_idx_reg;
    beat_cnt_next  = beat_cnt_reg;

    // Skid entry moves forward when the head is consumed.
    if (pop && occ_reg == 2'd2) begin
      entry0_next = entry1_reg;
    end
    // The arriving word lands in the first entry still free after the pop.
    // The read-issue rule ensures occ_after_pop is at most 1 here.
    if (pend_reg) begin
      if (occ_after_pop == 2'd0) begin
        entry0_next = bus.fifo_data_i;
      end else begin
        entry1_next = bus.fifo_data_i;
      end
    end

    if (pop) begin
      burst_idx_next = (burst_idx_reg == LAST_IDX) ? 16'd0 : burst_idx_reg + 16'd1;
      beat_cnt_next  = beat_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_reg       <= 2'd0;
      pend_reg      <= 1'b0;
      burst_idx_reg <= 16'd0;
      beat_cnt_reg  <= 16'd0;
      entry0_reg    <= '0;
      entry1_reg    <= '0;
    end else begin
      occ_reg       <= occ_next;
      pend_reg      <= rd_en;
      burst_idx_reg <= burst_idx_next;
      beat_cnt_reg  <= beat_cnt_next;
      entry0_reg    <= entry0_next;
      entry1_reg    <= entry1_next;
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = valid;
  assign bus.m_data_o     = entry0_reg;
  assign bus.m_last_o     = valid & (burst_idx_reg == LAST_IDX);
  assign bus.beat_cnt_o   = beat_cnt_reg;
endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  logic clk;
  logic rst;
  logic ready;
  logic ready1;
  int   checks;
  int   failures;
  int   cyc;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus1 ();

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.master)
  );
  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model for dut: one-cycle read latency, flushed by the shared reset.
  logic [7:0] fifo_mem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic [7:0] fifo_data;
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en_o) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end
  assign bus.fifo_empty_i = (rd_ptr == wr_ptr);
  assign bus.fifo_data_i  = fifo_data;
  assign bus.m_ready_i    = ready;

  // Endless source for dut1: yields 0,1,2,... after reset.
  logic [7:0] src1;
  logic [7:0] fifo_data1;
  always @(posedge clk) begin
    if (rst) begin
      src1 <= 8'd0;
    end else if (bus1.fifo_rd_en_o) begin
      fifo_data1 <= src1;
      src1       <= src1 + 8'd1;
    end
  end
  assign bus1.fifo_empty_i = 1'b0;
  assign bus1.fifo_data_i  = fifo_data1;
  assign bus1.m_ready_i    = ready1;

  // Monitor for dut: records beats, read pulses and stall-rule violations.
  logic [7:0] rx_data [$];
  logic       rx_last [$];
  int         rx_cyc [$];
  int         rd_cyc [$];
  int         stall_viol;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  initial begin
    stall_viol = 0;
    prev_stall = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.fifo_rd_en_o) rd_cyc.push_back(cyc);
    if (prev_stall && !rst) begin
      if (!(bus.m_valid_o && bus.m_data_o == prev_data && bus.m_last_o == prev_last))
        stall_viol = stall_viol + 1;
    end
    prev_stall = bus.m_valid_o && !ready && !rst;
    prev_data  = bus.m_data_o;
    prev_last  = bus.m_last_o;
    if (bus.m_valid_o && ready && !rst) begin
      rx_data.push_back(bus.m_data_o);
      rx_last.push_back(bus.m_last_o);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic push_word(input logic [7:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ready = 1'b0;
    ready1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (rx_data.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    push_word(8'hEE);
    @(negedge clk);
    checks++; if (bus.fifo_rd_en_o !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en_o); end
    checks++; if (bus.m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.m_valid_o); end
    checks++; if (bus.m_last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", bus.m_last_o); end
    checks++; if (bus.m_data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", bus.m_data_o); end
    checks++; if (bus.beat_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_beat_cnt: got %0d expected 0", bus.beat_cnt_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int rxb, rdb;
    bit ok;
    do_reset();
    rxb = rx_data.size();
    rdb = rd_cyc.size();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
    wait_rx(rxb + 5, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got %0d beats expected 5", rx_data.size() - rxb); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (rx_data[rxb+i] !== 8'h11 + 8'(i)) begin failures++; $display("FAIL basic_data[%0d]: got %h expected %h", i, rx_data[rxb+i], 8'h11 + 8'(i)); end
        checks++; if (rx_last[rxb+i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d]: got %b expected %b", i, rx_last[rxb+i], (i == 3)); end
      end
      checks++; if (rx_cyc[rxb] - rd_cyc[rdb] !== 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", rx_cyc[rxb] - rd_cyc[rdb]); end
    end
    @(negedge clk);
    checks++; if (bus.beat_cnt_o !== 16'd5) begin failures++; $display("FAIL basic_beat_cnt: got %0d expected 5", bus.beat_cnt_o); end
    checks++; if (bus.m_valid_o !== 1'b0) begin failures++; $display("FAIL basic_drained: got %b expected 0", bus.m_valid_o); end
    $display("test_basic done");
  endtask

  task automatic test_throughput();
    int rxb, rdb;
    bit ok;
    do_reset();
    rxb = rx_data.size();
    rdb = rd_cyc.size();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i));
    wait_rx(rxb + 8, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL thr_timeout: got %0d beats expected 8", rx_data.size() - rxb); end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (rx_data[rxb+i] !== 8'h80 + 8'(i)) begin failures++; $display("FAIL thr_data[%0d]: got %h expected %h", i, rx_data[rxb+i], 8'h80 + 8'(i)); end
        checks++; if (rx_last[rxb+i] !== (i == 3 || i == 7)) begin failures++; $display("FAIL thr_last[%0d]: got %b expected %b", i, rx_last[rxb+i], (i == 3 || i == 7)); end
        checks++; if (rx_cyc[rxb+i] !== rx_cyc[rxb] + i) begin failures++; $display("FAIL thr_cycle[%0d]: got %0d expected %0d", i, rx_cyc[rxb+i], rx_cyc[rxb] + i); end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (rd_cyc.size() - rdb !== 8) begin failures++; $display("FAIL thr_rd_pulses: got %0d expected 8", rd_cyc.size() - rdb); end
    checks++; if (bus.beat_cnt_o !== 16'd8) begin failures++; $display("FAIL thr_beat_cnt: got %0d expected 8", bus.beat_cnt_o); end
    $display("test_throughput done");
  endtask

  task automatic test_backpressure();
    int rxb, rdb, rel;
    bit ok;
    do_reset();
    rxb = rx_data.size();
    rdb = rd_cyc.size();
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    repeat (10) @(negedge clk);
    checks++; if (rd_cyc.size() - rdb !== 2) begin failures++; $display("FAIL bp_stall_reads: got %0d expected 2", rd_cyc.size() - rdb); end
    checks++; if (bus.m_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", bus.m_valid_o); end
    checks++; if (bus.m_data_o !== 8'hA0) begin failures++; $display("FAIL bp_hold_data: got %h expected a0", bus.m_data_o); end
    @(posedge clk); #1;
    ready = 1'b1;
    rel = cyc;
    wait_rx(rxb + 8, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d beats expected 8", rx_data.size() - rxb); end
    if (ok) begin
      checks++; if (rx_cyc[rxb] !== rel) begin failures++; $display("FAIL bp_release_cycle: got %0d expected %0d", rx_cyc[rxb], rel); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (rx_data[rxb+i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL bp_data[%0d]: got %h expected %h", i, rx_data[rxb+i], 8'hA0 + 8'(i)); end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (rx_data.size() - rxb !== 8) begin failures++; $display("FAIL bp_beat_total: got %0d expected 8", rx_data.size() - rxb); end
    checks++; if (rd_cyc.size() - rdb !== 8) begin failures++; $display("FAIL bp_rd_total: got %0d expected 8", rd_cyc.size() - rdb); end
    $display("test_backpressure done");
  endtask

  task automatic test_alternating();
    int rxb, svb;
    bit done;
    do_reset();
    rxb = rx_data.size();
    svb = stall_viol;
    for (int i = 0; i < 6; i++) push_word(8'h30 + 8'(i));
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_data.size() >= rxb + 6) begin
        done = 1'b1;
        break;
      end
      ready = ~ready;
    end
    ready = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL alt_timeout: got %0d beats expected 6", rx_data.size() - rxb); end
    if (done) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (rx_data[rxb+i] !== 8'h30 + 8'(i)) begin failures++; $display("FAIL alt_data[%0d]: got %h expected %h", i, rx_data[rxb+i], 8'h30 + 8'(i)); end
        checks++; if (rx_last[rxb+i] !== (i == 3)) begin failures++; $display("FAIL alt_last[%0d]: got %b expected %b", i, rx_last[rxb+i], (i == 3)); end
      end
    end
    @(negedge clk);
    checks++; if (bus.beat_cnt_o !== 16'd6) begin failures++; $display("FAIL alt_beat_cnt: got %0d expected 6", bus.beat_cnt_o); end
    checks++; if (stall_viol - svb !== 0) begin failures++; $display("FAIL alt_stall_stable: got %0d violations expected 0", stall_viol - svb); end
    $display("test_alternating done");
  endtask

  task automatic test_reset_mid();
    int rxb;
    bit ok;
    do_reset();
    rxb = rx_data.size();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h41 + 8'(i));
    wait_rx(rxb + 2, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout: got %0d beats expected 2", rx_data.size() - rxb); end
    // Next cycle: third word buffered, fourth in flight.
    @(posedge clk); #1;
    rst = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_valid_o !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", bus.m_valid_o); end
    checks++; if (bus.m_last_o !== 1'b0) begin failures++; $display("FAIL mid_last: got %b expected 0", bus.m_last_o); end
    checks++; if (bus.beat_cnt_o !== 16'd0) begin failures++; $display("FAIL mid_beat_cnt: got %0d expected 0", bus.beat_cnt_o); end
    checks++; if (bus.m_data_o !== 8'h00) begin failures++; $display("FAIL mid_data: got %h expected 00", bus.m_data_o); end
    checks++; if (rx_data.size() - rxb !== 2) begin failures++; $display("FAIL mid_pre_beats: got %0d expected 2", rx_data.size() - rxb); end
    @(posedge clk); #1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h51 + 8'(i));
    wait_rx(rxb + 6, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_post_timeout: got %0d beats expected 6", rx_data.size() - rxb); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_data[rxb+2+i] !== 8'h51 + 8'(i)) begin failures++; $display("FAIL mid_post_data[%0d]: got %h expected %h", i, rx_data[rxb+2+i], 8'h51 + 8'(i)); end
        checks++; if (rx_last[rxb+2+i] !== (i == 3)) begin failures++; $display("FAIL mid_post_last[%0d]: got %b expected %b", i, rx_last[rxb+2+i], (i == 3)); end
      end
    end
    @(negedge clk);
    checks++; if (bus.beat_cnt_o !== 16'd4) begin failures++; $display("FAIL mid_post_beat_cnt: got %0d expected 4", bus.beat_cnt_o); end
    $display("test_reset_mid done");
  endtask

  task automatic test_burst1_wrap();
    int n, bad_last, bad_data;
    do_reset();
    ready1 = 1'b1;
    n = 0;
    bad_last = 0;
    bad_data = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (bus1.m_valid_o && ready1) begin
        if (bus1.m_last_o !== 1'b1) bad_last++;
        if (bus1.m_data_o !== n[7:0]) bad_data++;
        n++;
        if (n == 65537) begin
          @(posedge clk); #1;
          ready1 = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    checks++; if (n !== 65537) begin failures++; $display("FAIL b1_beats: got %0d expected 65537", n); end
    checks++; if (bad_last !== 0) begin failures++; $display("FAIL b1_last_every_beat: got %0d misses expected 0", bad_last); end
    checks++; if (bad_data !== 0) begin failures++; $display("FAIL b1_data_order: got %0d errors expected 0", bad_data); end
    checks++; if (bus1.beat_cnt_o !== 16'd1) begin failures++; $display("FAIL b1_beat_cnt_wrap: got %0d expected 1", bus1.beat_cnt_o); end
    $display("test_burst1_wrap done beats=%0d", n);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    ready = 1'b0;
    ready1 = 1'b0;
    wr_ptr = 8'd0;
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_alternating();
    test_reset_mid();
    test_burst1_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion to `fifo_buffer`. Drains the FIFO through its `rd_en`/`data`/`empty` port and presents the words as a valid/ready stream, with a `last` marker every `BURST_LEN` beats. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the stream runs at one beat per clock under continuous `ready`. Sits between `fifo_buffer` and any downstream stream consumer.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the `fifo_buffer` `DATA_WIDTH`.
- `BURST_LEN`, default 4: beats per burst; `m_last_o` marks the final beat. Legal range 1..65535.
- `clk_i`  in  1: single clock; all logic on its rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `fifo_empty_i`  in  1: FIFO `empty_o`.
- `fifo_rd_en_o`  out  1: FIFO `rd_en_i`; a one-cycle pulse pops one word.
- `fifo_data_i`  in  DATA_WIDTH: FIFO `data_o`; valid the cycle after `fifo_rd_en_o` is high.
- `m_valid_o`  out  1: stream word valid.
- `m_ready_i`  in  1: downstream accepts; a beat transfers when `m_valid_o & m_ready_i`.
- `m_data_o`  out  DATA_WIDTH: stream data.
- `m_last_o`  out  1: current beat is the last beat of a burst.
- `beat_cnt_o`  out  16: total beats transferred since reset; wraps from 65535 to 0.

## Operation
- **State**
  - `occ` (0..2): words held in the 2-entry buffer. Entry 0 drives `m_data_o`; entry 1 is the skid entry.
  - `pend` (0/1): a read was issued last cycle and its data is arriving on `fifo_data_i` this cycle.
  - `burst_idx` (0..BURST_LEN-1): beat index within the current burst.
  - `beat_cnt`: total beat counter.
- **Read issue**
  - `pop = m_valid_o & m_ready_i`.
  - `fifo_rd_en_o = !rst_i & !fifo_empty_i & (occ + pend - pop < 2)`.
  - This is combinational from registers, `fifo_empty_i` and `m_ready_i`.
  - It never over-commits the buffer, so no word is ever dropped.
- **Capture**
  - When `pend` is set, `fifo_data_i` is written at the clock edge.
  - It goes to entry 0 if the buffer is empty after `pop`; otherwise it goes to entry 1.
  - On `pop` with `occ == 2`, entry 1 shifts into entry 0 in the same edge.
  - Order is strictly FIFO order.
- **Stream outputs**
  - `m_valid_o = (occ != 0)`.
  - `m_data_o` = entry 0.
  - `m_last_o = m_valid_o & (burst_idx == BURST_LEN-1)`.
- **Counters**
  - On `pop`, `burst_idx` increments and wraps to 0 after `BURST_LEN-1`. `beat_cnt` increments modulo 2^16.
  - With `BURST_LEN = 1`, every beat has `m_last_o = 1`.
- **Stall rules**
  - While `m_valid_o & !m_ready_i`, `m_data_o` and `m_last_o` hold stable.
  - `m_valid_o` does not drop until the beat is accepted.
- **Reset** (`rst_i` high at an edge)
  - `occ`, `pend`, `burst_idx` and `beat_cnt` clear to 0.
  - `fifo_rd_en_o` is forced low during reset.
  - A word in flight when reset is asserted (`pend = 1`) is discarded, as are buffered words. The FIFO has been popped for those words, so they are lost by design.
- **Empty FIFO:** no read is issued; buffered words still drain normally.

## Timing
- Reset values: `fifo_rd_en_o = 0`, `m_valid_o = 0`, `m_last_o = 0`, `m_data_o` = don't-care (zeros after reset), `beat_cnt_o = 0`.
- First-word latency: `fifo_empty_i` falls in cycle N, so `fifo_rd_en_o` is high in N, `fifo_data_i` is valid in N+1, and `m_valid_o` is high in N+2.
- Throughput:
  - One beat per cycle while `m_ready_i` stays high and the FIFO is non-empty.
  - Steady state is `occ = 1`, `pend = 1`, `pop = 1`, with a read issued every cycle.
- Backpressure:
  - With `m_ready_i` held low, at most 2 reads are issued.
  - After that, `fifo_rd_en_o` stays low until a pop.
  - On release, the first beat transfers in the same cycle `m_ready_i` rises.
- Simultaneous capture and pop at `occ = 1`: the new word replaces entry 0 and `occ` stays 1.
- Simultaneous capture and pop at `occ = 2`: entry 1 shifts to entry 0, the new word goes to entry 1, and `occ` stays 2.

## Test plan
- **Basic:** reset, write 5 words (0x11..0x15) into `fifo_buffer`, `m_ready_i = 1`.
  - Expect 5 beats in order.
  - `m_last_o` on beat 4 only.
  - `beat_cnt_o = 5`.
  - First `m_valid_o` 2 cycles after the first `fifo_rd_en_o`.
- **Full throughput:** 8 words pre-loaded, `m_ready_i = 1`.
  - Expect 8 consecutive beats on 8 consecutive cycles.
  - `m_last_o` on beats 4 and 8.
  - `fifo_rd_en_o` high for exactly 8 cycles.
- **Backpressure:** 8 words pre-loaded, `m_ready_i = 0` for 10 cycles, then 1.
  - Exactly 2 `fifo_rd_en_o` pulses occur during the stall.
  - `m_data_o` holds the first word.
  - All 8 words then arrive in order with none lost or duplicated.
- **Alternating ready:** 6 words, `m_ready_i` toggles every cycle.
  - Data order is preserved.
  - Each beat transfers only on a ready-high cycle.
  - `beat_cnt_o = 6` at the end.
- **Reset mid-operation:** 4 words; assert `rst_i` for one cycle right after the 2nd beat, while `pend = 1`.
  - All outputs return to reset values on the next cycle.
  - The in-flight word is dropped.
  - `burst_idx` restarts, so the next `m_last_o` comes after 4 more beats.
- **`BURST_LEN = 1` and counter wrap:** force `beat_cnt` near 65535 by streaming 65537 beats.
  - `m_last_o` is high on every beat.
  - `beat_cnt_o` reads 1 at the end.
